// File: rtl/axi_pkg.sv
// Shared AXI encodings and FSM state types for the SRAM slave.
package axi_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_e;

    typedef enum logic [1:0] {
        FIXED      = 2'b00,
        INCR       = 2'b01,
        WRAP       = 2'b10,
        BURST_RSVD = 2'b11
    } burst_e;

    typedef enum logic [1:0] {
        R_IDLE,
        R_WAIT,
        R_DATA
    } rd_state_e;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } wr_state_e;

    // Only FIXED and INCR are serviced; WRAP and the reserved code are errored.
    function automatic logic burst_supported(input logic [1:0] burst);
        return (burst == FIXED) || (burst == INCR);
    endfunction

endpackage

// File: rtl/sram_bytewise.sv
// DEPTH x DATA_W storage with one asynchronous read port and one
// byte-enabled synchronous write port. Contents are never reset.
module sram_bytewise #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 4096,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [IDX_W-1:0]      widx,
    input  logic [DATA_W/8-1:0]   wstrb,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [IDX_W-1:0]      ridx,
    output logic [DATA_W-1:0]     rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < DATA_W / 8; i++) begin
                if (wstrb[i]) begin
                    mem[widx][i*8 +: 8] <= wdata[i*8 +: 8];
                end
            end
        end
    end

    assign rdata = mem[ridx];

endmodule

// File: rtl/axi_sram_slave.sv
// AXI4-style SRAM slave with independent read and write burst engines,
// INCR/FIXED bursts and a configurable read latency.
module axi_sram_slave
    import axi_pkg::*;
#(
    parameter int                ADDR_W     = 32,
    parameter int                DATA_W     = 64,
    parameter int                DEPTH      = 4096,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = 32'h8000_0000,
    parameter int                RD_LATENCY = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   araddr,
    input  logic                arvalid,
    input  logic [1:0]          arburst,
    input  logic [7:0]          arlen,
    input  logic [2:0]          arsize,
    output logic                arready,
    output logic [DATA_W-1:0]   rdata,
    output logic [1:0]          rresp,
    output logic                rvalid,
    output logic                rlast,
    input  logic                rready,
    input  logic [ADDR_W-1:0]   awaddr,
    input  logic                awvalid,
    input  logic [1:0]          awburst,
    input  logic [7:0]          awlen,
    output logic                awready,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    input  logic                wlast,
    input  logic                wvalid,
    output logic                wready,
    output logic [1:0]          bresp,
    output logic                bvalid,
    input  logic                bready
);

    localparam int STRB_W  = DATA_W / 8;
    localparam int OFF_LSB = $clog2(STRB_W);
    localparam int IDX_W   = $clog2(DEPTH);
    localparam int CNT_W   = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

    rd_state_e          rd_state, rd_next;
    logic [ADDR_W-1:0]  rd_addr, rd_off;
    logic [7:0]         rd_len, rd_beat;
    logic [1:0]         rd_burst;
    logic [CNT_W-1:0]   lat_cnt;
    logic               rd_hit, rd_burst_ok, rd_last, ar_hs, r_hs;

    wr_state_e          wr_state, wr_next;
    logic [ADDR_W-1:0]  wr_addr, wr_off;
    logic [7:0]         wr_len, wr_beat;
    logic [1:0]         wr_burst;
    logic               wr_hit, wr_burst_ok, wr_last, wr_slverr, wr_decerr;
    logic               aw_hs, w_hs, b_hs, mem_we;

    logic [DATA_W-1:0]  mem_rdata;

    // Transfer size is implied by the fixed 64-bit word; arsize is not decoded.
    logic unused_arsize;
    assign unused_arsize = ^arsize;

    assign ar_hs = arvalid && arready;
    assign r_hs  = rvalid && rready;
    assign aw_hs = awvalid && awready;
    assign w_hs  = wvalid && wready;
    assign b_hs  = bvalid && bready;

    assign rd_off      = rd_addr - BASE_ADDR;
    assign rd_hit      = (rd_addr >= BASE_ADDR) && ((rd_off >> OFF_LSB) < ADDR_W'(DEPTH));
    assign rd_burst_ok = burst_supported(rd_burst);
    assign rd_last     = (rd_beat == rd_len);

    assign wr_off      = wr_addr - BASE_ADDR;
    assign wr_hit      = (wr_addr >= BASE_ADDR) && ((wr_off >> OFF_LSB) < ADDR_W'(DEPTH));
    assign wr_burst_ok = burst_supported(wr_burst);
    assign wr_last     = (wr_beat == wr_len);
    assign mem_we      = w_hs && wr_burst_ok && wr_hit;

    sram_bytewise #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_sram (
        .clk   (clk),
        .we    (mem_we),
        .widx  (wr_off[OFF_LSB +: IDX_W]),
        .wstrb (wstrb),
        .wdata (wdata),
        .ridx  (rd_off[OFF_LSB +: IDX_W]),
        .rdata (mem_rdata)
    );

    always_comb begin
        rd_next = rd_state;
        case (rd_state)
            R_IDLE:  if (ar_hs) rd_next = R_WAIT;
            R_WAIT:  if (lat_cnt == CNT_W'(RD_LATENCY - 1)) rd_next = R_DATA;
            R_DATA:  if (r_hs && rd_last) rd_next = R_IDLE;
            default: rd_next = R_IDLE;
        endcase
    end

    // arready is a flop so it stays low through reset and rises one edge later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_state <= R_IDLE;
            arready  <= 1'b0;
            rd_addr  <= '0;
            rd_len   <= '0;
            rd_beat  <= '0;
            rd_burst <= '0;
            lat_cnt  <= '0;
        end else begin
            rd_state <= rd_next;
            arready  <= (rd_next == R_IDLE);
            if (ar_hs) begin
                rd_addr  <= araddr;
                rd_len   <= arlen;
                rd_beat  <= '0;
                rd_burst <= arburst;
                lat_cnt  <= '0;
            end
            if (rd_state == R_WAIT) begin
                lat_cnt <= lat_cnt + 1'b1;
            end
            if (r_hs && !rd_last) begin
                rd_beat <= rd_beat + 1'b1;
                if (rd_burst == INCR) begin
                    rd_addr <= rd_addr + ADDR_W'(STRB_W);
                end
            end
        end
    end

    assign rvalid = (rd_state == R_DATA);
    assign rlast  = rvalid && rd_last;

    always_comb begin
        rresp = OKAY;
        rdata = '0;
        if (rvalid) begin
            if (!rd_burst_ok) begin
                rresp = SLVERR;
            end else if (!rd_hit) begin
                rresp = DECERR;
            end else begin
                rdata = mem_rdata;
            end
        end
    end

    always_comb begin
        wr_next = wr_state;
        case (wr_state)
            W_IDLE:  if (aw_hs) wr_next = W_DATA;
            W_DATA:  if (w_hs && wr_last) wr_next = W_RESP;
            W_RESP:  if (b_hs) wr_next = W_IDLE;
            default: wr_next = W_IDLE;
        endcase
    end

    // Error flags accumulate over the burst and are reported once on B.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_state  <= W_IDLE;
            awready   <= 1'b0;
            wr_addr   <= '0;
            wr_len    <= '0;
            wr_beat   <= '0;
            wr_burst  <= '0;
            wr_slverr <= 1'b0;
            wr_decerr <= 1'b0;
        end else begin
            wr_state <= wr_next;
            awready  <= (wr_next == W_IDLE);
            if (aw_hs) begin
                wr_addr   <= awaddr;
                wr_len    <= awlen;
                wr_beat   <= '0;
                wr_burst  <= awburst;
                wr_slverr <= 1'b0;
                wr_decerr <= 1'b0;
            end
            if (w_hs) begin
                if (!wr_burst_ok) begin
                    wr_slverr <= 1'b1;
                end else if (!wr_hit) begin
                    wr_decerr <= 1'b1;
                end
                if (wlast != wr_last) begin
                    wr_slverr <= 1'b1;
                end
                if (!wr_last) begin
                    wr_beat <= wr_beat + 1'b1;
                    if (wr_burst == INCR) begin
                        wr_addr <= wr_addr + ADDR_W'(STRB_W);
                    end
                end
            end
        end
    end

    assign wready = (wr_state == W_DATA);
    assign bvalid = (wr_state == W_RESP);

    always_comb begin
        bresp = OKAY;
        if (bvalid) begin
            if (wr_decerr) begin
                bresp = DECERR;
            end else if (wr_slverr) begin
                bresp = SLVERR;
            end
        end
    end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed self-checking bench for axi_sram_slave: reset values, full and
// strobed writes, stalled INCR reads, FIXED/WRAP bursts, decode errors, reset mid-burst.
module tb_axi_sram_slave;

    logic        clk;
    logic        rst;
    logic [31:0] araddr;
    logic        arvalid;
    logic [1:0]  arburst;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic        arready;
    logic [63:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rlast;
    logic        rready;
    logic [31:0] awaddr;
    logic        awvalid;
    logic [1:0]  awburst;
    logic [7:0]  awlen;
    logic        awready;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    int          total = 0;
    int          bad = 0;
    logic [63:0] wr_buf [8];
    logic [7:0]  wr_strb;
    logic [63:0] rd_data [8];
    logic [1:0]  rd_resp [8];
    logic        rd_last [8];
    int          rd_first_cyc;
    logic [1:0]  resp;
    int          n;

    axi_sram_slave dut (
        .clk     (clk),
        .rst     (rst),
        .araddr  (araddr),
        .arvalid (arvalid),
        .arburst (arburst),
        .arlen   (arlen),
        .arsize  (arsize),
        .arready (arready),
        .rdata   (rdata),
        .rresp   (rresp),
        .rvalid  (rvalid),
        .rlast   (rlast),
        .rready  (rready),
        .awaddr  (awaddr),
        .awvalid (awvalid),
        .awburst (awburst),
        .awlen   (awlen),
        .awready (awready),
        .wdata   (wdata),
        .wstrb   (wstrb),
        .wlast   (wlast),
        .wvalid  (wvalid),
        .wready  (wready),
        .bresp   (bresp),
        .bvalid  (bvalid),
        .bready  (bready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus();
        rst     = 1'b1;
        araddr  = '0;
        arvalid = 1'b0;
        arburst = 2'b01;
        arlen   = '0;
        arsize  = 3'd3;
        rready  = 1'b0;
        awaddr  = '0;
        awvalid = 1'b0;
        awburst = 2'b01;
        awlen   = '0;
        wdata   = '0;
        wstrb   = '0;
        wlast   = 1'b0;
        wvalid  = 1'b0;
        bready  = 1'b0;
    endtask

    // Starts and ends on a falling edge; beat data comes from wr_buf.
    task automatic writeBurst(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                              input bit early_last, output logic [1:0] b);
        int k;
        awaddr  = addr;
        awlen   = len;
        awburst = burst;
        awvalid = 1'b1;
        k = 0;
        while (!awready && k < 50) begin @(negedge clk); k++; end
        checkOutput("aw_wait", k < 50, 1);
        @(negedge clk);
        awvalid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            wdata  = wr_buf[i];
            wstrb  = wr_strb;
            wlast  = (i == int'(len)) || (early_last && i == 0);
            wvalid = 1'b1;
            k = 0;
            while (!wready && k < 50) begin @(negedge clk); k++; end
            checkOutput("w_wait", k < 50, 1);
            @(negedge clk);
        end
        wvalid = 1'b0;
        wlast  = 1'b0;
        bready = 1'b1;
        k = 0;
        while (!bvalid && k < 50) begin @(negedge clk); k++; end
        checkOutput("b_wait", k < 50, 1);
        b = bresp;
        @(negedge clk);
        bready = 1'b0;
    endtask

    // With toggle set rready alternates 1,0,1,0 and held outputs are checked while stalled.
    task automatic readBurst(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                             input bit toggle);
        int k, nb, cyc;
        bit ph, stalled;
        logic [63:0] hold_data;
        logic [1:0]  hold_resp;
        logic        hold_last;
        araddr  = addr;
        arlen   = len;
        arburst = burst;
        arvalid = 1'b1;
        k = 0;
        while (!arready && k < 50) begin @(negedge clk); k++; end
        checkOutput("ar_wait", k < 50, 1);
        @(negedge clk);
        arvalid = 1'b0;
        nb = 0;
        cyc = 0;
        ph = 1'b0;
        stalled = 1'b0;
        rd_first_cyc = -1;
        hold_data = '0;
        hold_resp = '0;
        hold_last = 1'b0;
        while (nb <= int'(len) && nb < 8 && cyc < 100) begin
            rready = toggle ? !ph : 1'b1;
            ph = !ph;
            if (rvalid) begin
                if (stalled) begin
                    checkOutput("stall_rdata", rdata, hold_data);
                    checkOutput("stall_rresp", rresp, hold_resp);
                    checkOutput("stall_rlast", rlast, hold_last);
                end
                if (rready) begin
                    if (nb == 0) rd_first_cyc = cyc;
                    rd_data[nb] = rdata;
                    rd_resp[nb] = rresp;
                    rd_last[nb] = rlast;
                    nb++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    hold_data = rdata;
                    hold_resp = rresp;
                    hold_last = rlast;
                end
            end
            @(negedge clk);
            cyc++;
        end
        rready = 1'b0;
        checkOutput("r_beats", nb, int'(len) + 1);
    endtask

    initial begin
        applyStimulus();
        repeat (2) @(negedge clk);
        checkOutput("rst_arready", arready, 0);
        checkOutput("rst_rvalid", rvalid, 0);
        checkOutput("rst_rlast", rlast, 0);
        checkOutput("rst_rresp", rresp, 0);
        checkOutput("rst_rdata", rdata, 0);
        checkOutput("rst_awready", awready, 0);
        checkOutput("rst_wready", wready, 0);
        checkOutput("rst_bvalid", bvalid, 0);
        checkOutput("rst_bresp", bresp, 0);
        rst = 1'b0;
        #1;
        checkOutput("arready_at_release", arready, 0);
        @(negedge clk);
        checkOutput("arready_post_reset", arready, 1);
        checkOutput("awready_post_reset", awready, 1);

        // Full-word write then read back, including the latency and AR turnaround.
        wr_buf[0] = 64'h1122_3344_5566_7788;
        wr_strb   = 8'hFF;
        writeBurst(32'h8000_0010, 8'd0, 2'b01, 1'b0, resp);
        checkOutput("wr_full_bresp", resp, 2'b00);
        readBurst(32'h8000_0010, 8'd0, 2'b01, 1'b0);
        checkOutput("rd_full_data", rd_data[0], 64'h1122_3344_5566_7788);
        checkOutput("rd_full_resp", rd_resp[0], 2'b00);
        checkOutput("rd_full_last", rd_last[0], 1'b1);
        checkOutput("rd_latency", rd_first_cyc, 1);
        checkOutput("arready_b2b", arready, 1);

        // Lower four lanes only.
        wr_buf[0] = 64'hFFFF_FFFF_FFFF_FFFF;
        wr_strb   = 8'h0F;
        writeBurst(32'h8000_0010, 8'd0, 2'b01, 1'b0, resp);
        checkOutput("wr_strb_bresp", resp, 2'b00);
        readBurst(32'h8000_0010, 8'd0, 2'b01, 1'b0);
        checkOutput("rd_strb_data", rd_data[0], 64'h1122_3344_FFFF_FFFF);

        // Four-beat INCR write, then stalled four-beat INCR read.
        wr_buf[0] = 64'hA5A5_0000_0000_0000;
        wr_buf[1] = 64'hA5A5_0000_0000_0001;
        wr_buf[2] = 64'hA5A5_0000_0000_0002;
        wr_buf[3] = 64'hA5A5_0000_0000_0003;
        wr_strb   = 8'hFF;
        writeBurst(32'h8000_0000, 8'd3, 2'b01, 1'b0, resp);
        checkOutput("wr_incr_bresp", resp, 2'b00);
        readBurst(32'h8000_0000, 8'd3, 2'b01, 1'b1);
        checkOutput("incr_d0", rd_data[0], 64'hA5A5_0000_0000_0000);
        checkOutput("incr_d1", rd_data[1], 64'hA5A5_0000_0000_0001);
        checkOutput("incr_d2", rd_data[2], 64'hA5A5_0000_0000_0002);
        checkOutput("incr_d3", rd_data[3], 64'hA5A5_0000_0000_0003);
        checkOutput("incr_r0", rd_resp[0], 2'b00);
        checkOutput("incr_r3", rd_resp[3], 2'b00);
        checkOutput("incr_l0", rd_last[0], 1'b0);
        checkOutput("incr_l1", rd_last[1], 1'b0);
        checkOutput("incr_l2", rd_last[2], 1'b0);
        checkOutput("incr_l3", rd_last[3], 1'b1);

        // Decode errors below the base and one word past the top.
        wr_buf[0] = 64'hDEAD_BEEF_0000_0FFF;
        writeBurst(32'h8000_7FF8, 8'd0, 2'b01, 1'b0, resp);
        checkOutput("wr_top_bresp", resp, 2'b00);
        readBurst(32'h7FFF_FFF8, 8'd0, 2'b01, 1'b0);
        checkOutput("below_rresp", rd_resp[0], 2'b11);
        checkOutput("below_rdata", rd_data[0], 64'h0);
        checkOutput("below_rlast", rd_last[0], 1'b1);
        readBurst(32'h8000_8000, 8'd0, 2'b01, 1'b0);
        checkOutput("above_rresp", rd_resp[0], 2'b11);
        checkOutput("above_rdata", rd_data[0], 64'h0);
        wr_buf[0] = 64'h5555_5555_5555_5555;
        writeBurst(32'h8000_8000, 8'd0, 2'b01, 1'b0, resp);
        checkOutput("above_bresp", resp, 2'b11);
        writeBurst(32'h7FFF_FFF8, 8'd0, 2'b01, 1'b0, resp);
        checkOutput("below_bresp", resp, 2'b11);
        readBurst(32'h8000_0000, 8'd0, 2'b01, 1'b0);
        checkOutput("word0_intact", rd_data[0], 64'hA5A5_0000_0000_0000);
        readBurst(32'h8000_7FF8, 8'd0, 2'b01, 1'b0);
        checkOutput("word_top_intact", rd_data[0], 64'hDEAD_BEEF_0000_0FFF);

        // wlast asserted on the first of two beats: data lands, response is SLVERR.
        wr_buf[0] = 64'hB0B0_B0B0_0000_0020;
        wr_buf[1] = 64'hB1B1_B1B1_0000_0028;
        writeBurst(32'h8000_0020, 8'd1, 2'b01, 1'b1, resp);
        checkOutput("early_wlast_bresp", resp, 2'b10);
        readBurst(32'h8000_0020, 8'd1, 2'b01, 1'b0);
        checkOutput("early_wlast_d0", rd_data[0], 64'hB0B0_B0B0_0000_0020);
        checkOutput("early_wlast_d1", rd_data[1], 64'hB1B1_B1B1_0000_0028);

        // FIXED repeats one word; WRAP is rejected.
        readBurst(32'h8000_0008, 8'd1, 2'b00, 1'b0);
        checkOutput("fixed_d0", rd_data[0], 64'hA5A5_0000_0000_0001);
        checkOutput("fixed_d1", rd_data[1], 64'hA5A5_0000_0000_0001);
        checkOutput("fixed_l0", rd_last[0], 1'b0);
        checkOutput("fixed_l1", rd_last[1], 1'b1);
        readBurst(32'h8000_0000, 8'd0, 2'b10, 1'b0);
        checkOutput("wrap_rresp", rd_resp[0], 2'b10);
        checkOutput("wrap_rdata", rd_data[0], 64'h0);

        // Reset while the second beat of a four-beat read is on the bus.
        araddr  = 32'h8000_0000;
        arlen   = 8'd3;
        arburst = 2'b01;
        arvalid = 1'b1;
        n = 0;
        while (!arready && n < 50) begin @(negedge clk); n++; end
        checkOutput("rst_ar_wait", n < 50, 1);
        @(negedge clk);
        arvalid = 1'b0;
        rready  = 1'b1;
        n = 0;
        while (!rvalid && n < 50) begin @(negedge clk); n++; end
        checkOutput("rst_r_wait", n < 50, 1);
        @(negedge clk);
        checkOutput("beat2_valid", rvalid, 1);
        checkOutput("beat2_data", rdata, 64'hA5A5_0000_0000_0001);
        rready = 1'b0;
        rst    = 1'b1;
        #1;
        checkOutput("midrst_rvalid", rvalid, 0);
        checkOutput("midrst_arready", arready, 0);
        checkOutput("midrst_rlast", rlast, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("midrst_release_arready", arready, 0);
        @(negedge clk);
        checkOutput("midrst_arready_back", arready, 1);
        readBurst(32'h8000_0000, 8'd0, 2'b01, 1'b0);
        checkOutput("after_rst_data", rd_data[0], 64'hA5A5_0000_0000_0000);
        checkOutput("after_rst_resp", rd_resp[0], 2'b00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
